// File: rtl/des_pkg.sv
// Shared DES definitions: controller state encoding, round count, subkey index
// width and the per-round key-schedule left-shift table.
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } des_state_t;

  localparam int DES_ROUNDS = 16;
  localparam int DES_IDX_W  = 5;

  // Bit (r-1) set means round r rotates the key halves by one; all others by two.
  localparam logic [15:0] DES_SHIFT_ONE = 16'b1000_0001_0000_0011;

  function automatic logic [1:0] des_shift(input logic [4:0] round);
    logic [3:0] r;
    r = 4'(round - 5'd1);
    return DES_SHIFT_ONE[r] ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/des_round_counter.sv
// Round counter and subkey-index generator: counts 1..ROUNDS and maps the count
// to an ascending (encrypt) or descending (decrypt) registered subkey index.
module des_round_counter
  import des_pkg::*;
#(
  parameter int ROUNDS = DES_ROUNDS,
  parameter int IDX_W  = DES_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic             dir,
  input  logic             enable,
  output logic [IDX_W-1:0] cnt,
  output logic [IDX_W-1:0] key_idx,
  output logic             last
);

  localparam logic [IDX_W-1:0] ROUNDS_I  = IDX_W'(ROUNDS);
  localparam logic [IDX_W-1:0] ROUNDS_P1 = IDX_W'(ROUNDS + 1);

  logic [IDX_W-1:0] cnt_d;
  logic [IDX_W-1:0] idx_d;
  logic             dir_q;
  logic             dir_d;

  always_comb begin
    cnt_d = cnt;
    dir_d = dir_q;
    if (clear) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (start) begin
      cnt_d = IDX_W'(1);
      dir_d = dir;
    end else if (enable) begin
      // the final round returns the count to zero so it can never wrap
      cnt_d = (cnt == ROUNDS_I) ? '0 : cnt + 1'b1;
    end

    idx_d = '0;
    if (cnt_d != '0) begin
      idx_d = dir_d ? (ROUNDS_P1 - cnt_d) : cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      dir_q   <= 1'b0;
      key_idx <= '0;
      last    <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      dir_q   <= dir_d;
      key_idx <= idx_d;
      last    <= (cnt_d == ROUNDS_I);
    end
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Sequencing controller for an iterative DES engine: job handshake, datapath
// load pulse, 16 round enables with subkey index, and result back-pressure.
//
// state   | meaning
// --------+-----------------------------------
// IDLE    | no job in progress
// RUN     | rounds in progress
// DONE    | result held for the consumer
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int ROUNDS = DES_ROUNDS,
  parameter int IDX_W  = DES_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in_decrypt,
  output logic             in_ready,
  output logic             load_en,
  output logic             round_en,
  output logic [IDX_W-1:0] key_idx,
  output logic             last_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [IDX_W-1:0] ROUNDS_I = IDX_W'(ROUNDS);

  des_state_t       state_q;
  des_state_t       state_d;
  logic             accept;
  logic [IDX_W-1:0] cnt;

  assign in_ready = !abort && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign load_en  = accept;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (cnt == ROUNDS_I) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = accept ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      round_en  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_en  <= (state_d == ST_RUN);
      out_valid <= (state_d == ST_DONE);
      busy      <= (state_d != ST_IDLE);
    end
  end

  des_round_counter #(
    .ROUNDS(ROUNDS),
    .IDX_W (IDX_W)
  ) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (abort),
    .start  (accept),
    .dir    (in_decrypt),
    .enable (state_q == ST_RUN),
    .cnt    (cnt),
    .key_idx(key_idx),
    .last   (last_round)
  );

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed bench for des_round_ctrl: handshake, round/subkey sequencing,
// back-pressure, back-to-back jobs, abort and asynchronous reset.
module tb_des_round_ctrl;

  localparam int R = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_decrypt = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       load_en;
  logic       round_en;
  logic [4:0] key_idx;
  logic       last_round;
  logic       out_valid;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  des_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_decrypt(in_decrypt),
    .in_ready  (in_ready),
    .load_en   (load_en),
    .round_en  (round_en),
    .key_idx   (key_idx),
    .last_round(last_round),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // inputs change at posedge+1, checks run at posedge+4
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_rounds(input bit dec);
    for (int i = 1; i <= R; i++) begin
      in_decrypt = 1'(i & 1);
      #3;
      chk($sformatf("r%0d round_en", i), 32'(round_en), 32'd1);
      chk($sformatf("r%0d key_idx", i), 32'(key_idx), dec ? 32'(R + 1 - i) : 32'(i));
      chk($sformatf("r%0d last", i), 32'(last_round), 32'(i == R));
      chk($sformatf("r%0d load_en", i), 32'(load_en), 32'd0);
      chk($sformatf("r%0d in_ready", i), 32'(in_ready), 32'd0);
      chk($sformatf("r%0d out_valid", i), 32'(out_valid), 32'd0);
      step();
    end
  endtask

  task automatic finish_job(input int stall);
    for (int s = 0; s < stall; s++) begin
      #3;
      chk("hold out_valid", 32'(out_valid), 32'd1);
      chk("hold round_en", 32'(round_en), 32'd0);
      chk("hold key_idx", 32'(key_idx), 32'd0);
      chk("hold in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #3;
    chk("done out_valid", 32'(out_valid), 32'd1);
    chk("done in_ready", 32'(in_ready), 32'd1);
    chk("done busy", 32'(busy), 32'd1);
    step();
    out_ready = 1'b0;
    #3;
    chk("idle out_valid", 32'(out_valid), 32'd0);
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle in_ready", 32'(in_ready), 32'd1);
    step();
  endtask

  task automatic run_job(input bit dec, input int stall);
    in_valid   = 1'b1;
    in_decrypt = dec;
    #3;
    chk("acc in_ready", 32'(in_ready), 32'd1);
    chk("acc load_en", 32'(load_en), 32'd1);
    chk("acc round_en", 32'(round_en), 32'd0);
    step();
    in_valid = 1'b0;
    run_rounds(dec);
    finish_job(stall);
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      if (round_en && (key_idx < 5'd1 || key_idx > 5'(R))) begin
        n_err++;
        $display("FAIL a_idx: key_idx %0d with round_en", key_idx);
      end
      if (last_round && !round_en) begin
        n_err++;
        $display("FAIL a_last: last_round without round_en");
      end
      if (load_en && round_en) begin
        n_err++;
        $display("FAIL a_excl: load_en and round_en together");
      end
    end
  end

  logic ov_hold = 1'b0;
  always @(posedge clk) begin
    if (rst_n && ov_hold && !out_valid) begin
      n_err++;
      $display("FAIL a_ov: out_valid dropped without out_ready");
    end
    ov_hold <= rst_n && out_valid && !out_ready && !abort;
  end

  initial begin
    bit seen_ov;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    chk("rst round_en", 32'(round_en), 32'd0);
    chk("rst key_idx", 32'(key_idx), 32'd0);
    chk("rst last", 32'(last_round), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst load_en", 32'(load_en), 32'd0);
    step();

    // encrypt then decrypt, single jobs
    run_job(1'b0, 0);
    run_job(1'b1, 1);

    // back-pressure for 5 cycles then back-to-back accept
    in_valid = 1'b1;
    in_decrypt = 1'b0;
    #3;
    chk("b2b acc load_en", 32'(load_en), 32'd1);
    step();
    in_valid = 1'b0;
    run_rounds(1'b0);
    for (int s = 0; s < 5; s++) begin
      #3;
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_decrypt = 1'b1;
    #3;
    chk("b2b in_ready", 32'(in_ready), 32'd1);
    chk("b2b load_en", 32'(load_en), 32'd1);
    chk("b2b out_valid", 32'(out_valid), 32'd1);
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    run_rounds(1'b1);
    finish_job(0);

    // in_valid held during the run with in_decrypt toggling
    in_valid = 1'b1;
    in_decrypt = 1'b0;
    #3;
    chk("held acc load_en", 32'(load_en), 32'd1);
    step();
    run_rounds(1'b0);
    #3;
    chk("held done in_ready", 32'(in_ready), 32'd0);
    chk("held done load_en", 32'(load_en), 32'd0);
    chk("held done out_valid", 32'(out_valid), 32'd1);
    step();
    in_valid = 1'b0;
    finish_job(0);

    // abort at round 7, with a competing request on the abort edge
    in_valid = 1'b1;
    in_decrypt = 1'b0;
    #3;
    chk("ab acc load_en", 32'(load_en), 32'd1);
    step();
    in_valid = 1'b0;
    for (int i = 1; i < 7; i++) begin
      #3;
      chk("ab pre key_idx", 32'(key_idx), 32'(i));
      step();
    end
    abort = 1'b1;
    in_valid = 1'b1;
    #3;
    chk("ab r7 key_idx", 32'(key_idx), 32'd7);
    chk("ab in_ready", 32'(in_ready), 32'd0);
    chk("ab load_en", 32'(load_en), 32'd0);
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    #3;
    chk("ab round_en", 32'(round_en), 32'd0);
    chk("ab key_idx", 32'(key_idx), 32'd0);
    chk("ab last", 32'(last_round), 32'd0);
    chk("ab busy", 32'(busy), 32'd0);
    chk("ab in_ready2", 32'(in_ready), 32'd1);
    step();
    seen_ov = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #3;
      if (out_valid || round_en) seen_ov = 1'b1;
      step();
    end
    chk("ab no output", 32'(seen_ov), 32'd0);
    run_job(1'b0, 0);

    // asynchronous reset between edges during round 10
    in_valid = 1'b1;
    in_decrypt = 1'b1;
    #3;
    chk("rs acc load_en", 32'(load_en), 32'd1);
    step();
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) step();
    #3;
    chk("rs r10 key_idx", 32'(key_idx), 32'd7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rs round_en", 32'(round_en), 32'd0);
    chk("rs key_idx", 32'(key_idx), 32'd0);
    chk("rs last", 32'(last_round), 32'd0);
    chk("rs out_valid", 32'(out_valid), 32'd0);
    chk("rs busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    #3;
    chk("rs in_ready", 32'(in_ready), 32'd1);
    chk("rs round_en2", 32'(round_en), 32'd0);
    step();
    run_job(1'b0, 0);

    // mixed directions and stalls
    for (int j = 0; j < 30; j++) begin
      run_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/des_round_ctrl.md
Name: des_round_ctrl

Overview:
Sequencing controller for an iterative DES engine built around the parallel subkey generator (K1..K16 available combinationally from the loaded key). It accepts one block and key per job through a valid/ready handshake and pulses the datapath load. It then steps 16 round enables, driving the subkey-select index: ascending for encrypt, descending for decrypt. It presents the result with valid/ready back-pressure.

Parameters:
ROUNDS, 16, number of Feistel rounds; also the maximum subkey index.
IDX_W, 5, width of the subkey index; must satisfy 2**IDX_W > ROUNDS.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
abort  in  1  synchronous job cancel; highest priority after reset
in_valid  in  1  job request; block and key are stable on the datapath inputs
in_decrypt  in  1  direction of the job; sampled only on accept (1 = decrypt)
in_ready  out  1  controller can accept a job this cycle
load_en  out  1  datapath loads the block, applies IP and latches the key
round_en  out  1  datapath performs one round this cycle
key_idx  out  IDX_W  subkey select, 1..ROUNDS; 0 when no round is active
last_round  out  1  high with the final round_en; datapath skips L/R swap and applies FP
out_valid  out  1  result register holds a completed block
out_ready  in  1  consumer takes the result
busy  out  1  state is not IDLE

Behaviour:
- Reset (rst_n=0, asynchronous) and abort (next edge) give identical results:
  - state=IDLE, counter=0, dir=0.
  - round_en=0, last_round=0, key_idx=0, out_valid=0, busy=0.
- States:
  - IDLE: no job in progress.
  - RUN: rounds in progress.
  - DONE: result held for the consumer.
- Combinational outputs:
  - in_ready = (state==IDLE) | (state==DONE & out_ready); forced 0 while abort=1.
  - accept = in_valid & in_ready.
  - load_en = accept; this is its only combinational path.
- Registered outputs: round_en, key_idx, last_round, out_valid, busy.
- On accept:
  - dir <= in_decrypt, cnt <= 1, next state RUN.
  - The next cycle presents round_en=1 and key_idx = (dir ? ROUNDS : 1).
- In RUN, each cycle:
  - round_en=1.
  - key_idx = dir ? ROUNDS+1-cnt : cnt.
  - last_round = (cnt==ROUNDS).
  - cnt increments; after cnt==ROUNDS the next state is DONE.
- Latency: accept at cycle T; rounds occupy T+1..T+ROUNDS; out_valid=1 from T+ROUNDS+1.
- DONE:
  - out_valid held until out_ready=1.
  - out_ready without a new accept -> IDLE.
  - out_ready with a same-cycle accept -> RUN (back-to-back).
  - Back-to-back throughput: one block per ROUNDS+1 cycles.
- in_valid during RUN is ignored; in_ready=0 and the job is not queued.
- in_decrypt changes after accept have no effect on the job in flight.
- Abort mid-run: round_en drops on the next cycle; no out_valid for the cancelled job. The abort edge also suppresses accept.
- The counter never wraps: cnt is cleared on entering DONE or IDLE, and key_idx never leaves 1..ROUNDS while round_en=1.
- Assertions for verification:
  - round_en implies key_idx within 1..ROUNDS.
  - last_round implies round_en.
  - load_en and round_en are never high together.
  - out_valid is stable while !out_ready.

Decomposition:
- des_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - DES_ROUNDS=16;
  - the subkey index width;
  - the per-round left-shift table (1,2,9,16 shift by 1; others by 2), shared with the key-schedule code.
- One natural sub-module, des_round_counter:
  - inputs: clear, start, dir, enable;
  - outputs: cnt, key_idx, last.
  - It isolates the ascending/descending index arithmetic.
- The FSM and handshake stay in des_round_ctrl.

Test Plan:
1. Encrypt single job: in_valid=1, in_decrypt=0 at cycle 0 -> load_en=1 at cycle 0; key_idx=1,2,...,16 on cycles 1..16; last_round only at cycle 16; out_valid=1 at cycle 17. Connected to the DES datapath with key 133457799BBCDFF1 and plaintext 0123456789ABCDEF -> output 85E813540F0AB405.
2. Decrypt: same key, ciphertext 85E813540F0AB405, in_decrypt=1 -> key_idx=16,15,...,1 on cycles 1..16; output 0123456789ABCDEF.
3. Back-pressure and back-to-back: out_ready=0 for 5 cycles after out_valid -> out_valid and the result stay stable, in_ready=0. Then out_ready=1 with in_valid=1 -> load_en the same cycle, next key_idx=1, no idle gap.
4. Abort at round 7 (key_idx=7) -> the next cycle has round_en=0, key_idx=0, busy=0, state IDLE, and no out_valid. The following job completes normally with correct output.
5. Async reset mid-run (rst_n low between clock edges at round 10) -> all registered outputs are 0 immediately. After release, in_ready=1 and the next job starts with key_idx=1.
6. in_valid held high during RUN with in_decrypt toggling -> no extra load_en and the key_idx sequence is unchanged. Randomized 1000-job run checked against a DES reference model.
